// File: rtl/debounced_edge_pio.sv
// Debounced, edge-capturing parallel input port with an Avalon-MM slave.
// Raw inputs are synchronised, then debounced per channel. Qualified edges of
// the debounced state latch into edge_capture, which raises a level interrupt
// through irq_mask.
//
// Bus handshake: Avalon-MM with no wait states. A read strobe sampled on a
// rising edge loads readdata on that edge, so data is valid the following
// cycle. readdata holds its value while read is low. A write strobe is
// accepted on the edge it is sampled. A read and a write in the same cycle
// return the value the register held before the write.
module debounced_edge_pio #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 50000,
  parameter int               EDGE_MODE       = 0,
  parameter logic [WIDTH-1:0] INIT            = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] pio_in,
  input  logic [1:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [CW-1:0]    r_cnt [WIDTH];
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic [31:0]      r_readdata;

  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] w_w1c;
  logic [31:0]      w_rd_word;
  logic             w_unused_wdata;

  // Only the low WIDTH bits of writedata carry meaning.
  assign w_unused_wdata = &{1'b0, writedata};

  // Two-flop synchroniser; reset to INIT so a quiet input sees no change.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_meta <= INIT;
      r_sync <= INIT;
    end else begin
      r_meta <= pio_in;
      r_sync <= r_meta;
    end
  end

  // Per-channel debounce: count consecutive cycles where sync differs from
  // stable; accept the new level once the count reaches DEBOUNCE_CYCLES-1.
  // Any return to the stable level restarts the count, so it cannot wrap.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_stable <= INIT;
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_sync[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == CNT_MAX) begin
          r_stable[i] <= r_sync[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Delayed copy of stable for edge detection.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_stable_d <= INIT;
    else             r_stable_d <= r_stable;
  end

  // Edge qualifier selected by EDGE_MODE: 0 rising, 1 falling, otherwise any.
  always_comb begin
    w_edge = r_stable ^ r_stable_d;
    if (EDGE_MODE == 0)      w_edge = r_stable & ~r_stable_d;
    else if (EDGE_MODE == 1) w_edge = ~r_stable & r_stable_d;
  end

  // Write-one-to-clear mask for edge_capture.
  always_comb begin
    w_w1c = '0;
    if (write && (address == 2'd2)) w_w1c = writedata[WIDTH-1:0];
  end

  // irq_mask register.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)                       r_mask <= '0;
    else if (write && (address == 2'd1))   r_mask <= writedata[WIDTH-1:0];
  end

  // Edge capture: a new edge is ORed in after the clear, so set wins.
  // Capture is independent of irq_mask.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_cap <= '0;
    else             r_cap <= (r_cap & ~w_w1c) | w_edge;
  end

  // Read mux; unused upper bits read as zero.
  always_comb begin
    w_rd_word = '0;
    case (address)
      2'd0:    w_rd_word[WIDTH-1:0] = r_stable;
      2'd1:    w_rd_word[WIDTH-1:0] = r_mask;
      2'd2:    w_rd_word[WIDTH-1:0] = r_cap;
      default: w_rd_word[WIDTH-1:0] = r_sync;
    endcase
  end

  // Registered read data, loaded only on read strobes.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) r_readdata <= '0;
    else if (read)   r_readdata <= w_rd_word;
  end

  assign readdata = r_readdata;
  assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_debounced_edge_pio.sv
// Bench for debounced_edge_pio: DUT A (rising edges, INIT=0) and DUT B
// (falling edges, INIT=F) share clock, reset and the bus. Reads push the
// expected word into a queue; a monitor compares readdata one cycle later.
module tb_debounced_edge_pio;

  localparam int W = 4;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Shared bus
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;

  logic [W-1:0] pio_a, pio_b;
  logic [31:0]  readdata_a, readdata_b;
  logic         irq_a, irq_b;

  debounced_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_MODE(0), .INIT(4'h0)) u_dut_a (
    .clk_clk(clk), .reset_reset(rst), .pio_in(pio_a), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata_a), .irq(irq_a)
  );

  debounced_edge_pio #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_MODE(1), .INIT(4'hF)) u_dut_b (
    .clk_clk(clk), .reset_reset(rst), .pio_in(pio_b), .address(address),
    .read(read), .write(write), .writedata(writedata),
    .readdata(readdata_b), .irq(irq_b)
  );

  // Scoreboard
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  bit          sel_q[$];
  logic        rd_q = 1'b0;
  logic [31:0] mon_exp, mon_got;
  bit          mon_sel;

  always @(posedge clk) rd_q <= read;

  // Monitor: readdata is valid the cycle after a sampled read.
  always @(negedge clk) begin
    if (rd_q) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL readdata: read with no queued expectation");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_sel = sel_q.pop_front();
        mon_got = mon_sel ? readdata_b : readdata_a;
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL readdata_%s: got %h expected %h at %0t",
                   mon_sel ? "b" : "a", mon_got, mon_exp, $time);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] e, input bit s = 1'b0);
    address = a;
    read    = 1'b1;
    exp_q.push_back(e);
    sel_q.push_back(s);
    step();
    read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write = 1'b0;
  endtask

  task automatic rw(input logic [1:0] a, input logic [31:0] d, input logic [31:0] e);
    address   = a;
    writedata = d;
    write     = 1'b1;
    read      = 1'b1;
    exp_q.push_back(e);
    sel_q.push_back(1'b0);
    step();
    write = 1'b0;
    read  = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] e);
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, e, $time);
    end
  endtask

  initial begin
    rst = 1'b1; read = 1'b0; write = 1'b0; address = 2'd0; writedata = '0;
    pio_a = 4'h0; pio_b = 4'hF;
    idle(3);
    check("reset_readdata_a", readdata_a, 32'h0);
    check("reset_irq_a", {31'b0, irq_a}, 32'h0);
    check("reset_readdata_b", readdata_b, 32'h0);
    check("reset_irq_b", {31'b0, irq_b}, 32'h0);
    rst = 1'b0;
    idle(2);
    rd(2'd0, 32'h0);
    rd(2'd0, 32'hF, 1'b1);
    rd(2'd2, 32'h0, 1'b1);

    // Rising edge on bit 0: sync after 2 edges, stable after 6, capture after 7
    pio_a = 4'h1;
    step();                 // e1
    rd(2'd3, 32'h0);        // e2 sees sync before e2
    rd(2'd3, 32'h1);        // e3 sees sync after e2
    idle(2);                // e4, e5
    rd(2'd0, 32'h0);        // e6 sees stable after e5
    rd(2'd0, 32'h1);        // e7 sees stable after e6
    rd(2'd2, 32'h1);        // e8 sees capture after e7
    idle(2);
    check("readdata_hold", readdata_a, 32'h1);
    check("irq_masked_off", {31'b0, irq_a}, 32'h0);
    rd(2'd1, 32'h0);
    wr(2'd2, 32'h1);
    rd(2'd2, 32'h0);
    pio_a = 4'h0;           // falling edge is not captured in rising mode
    idle(10);
    rd(2'd0, 32'h0);
    rd(2'd2, 32'h0);

    // Masked interrupt rises with capture, falls after W1C
    wr(2'd1, 32'h1);
    rd(2'd1, 32'h1);
    pio_a = 4'h1;
    idle(6);
    check("irq_before_capture", {31'b0, irq_a}, 32'h0);
    step();                 // e7
    check("irq_on_capture", {31'b0, irq_a}, 32'h1);
    wr(2'd2, 32'h1);        // e8
    check("irq_after_w1c", {31'b0, irq_a}, 32'h0);
    rd(2'd2, 32'h0);

    // W1C on the same edge as a new capture: set wins
    pio_a = 4'h0;
    idle(10);
    rd(2'd2, 32'h0);
    pio_a = 4'h1;
    idle(6);
    wr(2'd2, 32'h1);        // e7: capture and clear together
    check("irq_set_wins", {31'b0, irq_a}, 32'h1);
    rd(2'd2, 32'h1);
    wr(2'd2, 32'hF);
    check("irq_cleared_all", {31'b0, irq_a}, 32'h0);

    // Glitches of 3 cycles on bit 1 never pass the debouncer
    repeat (5) begin
      pio_a = 4'h3;
      idle(3);
      pio_a = 4'h1;
      idle(3);
    end
    idle(6);
    rd(2'd0, 32'h1);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h1);

    // Register map: read-during-write, ignored addresses, upper bits zero
    rw(2'd1, 32'h3, 32'h1);
    rd(2'd1, 32'h3);
    wr(2'd0, 32'hF);
    rd(2'd0, 32'h1);
    wr(2'd3, 32'hF);
    rd(2'd3, 32'h1);
    wr(2'd1, 32'hFFFF_FFFF);
    rd(2'd1, 32'hF);

    // Capture is independent of mask; W1C only clears written ones
    wr(2'd1, 32'h0);
    pio_a = 4'h5;
    idle(8);
    rd(2'd2, 32'h4);
    check("irq_mask_zero", {31'b0, irq_a}, 32'h0);
    wr(2'd1, 32'h4);
    check("irq_mask_enable", {31'b0, irq_a}, 32'h1);
    wr(2'd2, 32'h3);
    rd(2'd2, 32'h4);
    wr(2'd2, 32'h4);
    rd(2'd2, 32'h0);

    // Reset two cycles into a debounce with pio back at INIT
    pio_a = 4'h0;
    idle(10);
    wr(2'd1, 32'hF);
    pio_a = 4'h4;
    idle(2);
    rst = 1'b1;
    pio_a = 4'h0;
    idle(2);
    rst = 1'b0;
    repeat (12) begin
      step();
      check("irq_after_abandon", {31'b0, irq_a}, 32'h0);
    end
    rd(2'd0, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd1, 32'h0);

    // Release with pio differing from INIT: capture after 7 edges
    rst = 1'b1;
    pio_a = 4'h1;
    idle(2);
    rst = 1'b0;
    idle(6);                // e1..e6
    rd(2'd2, 32'h0);        // e7 sees capture after e6
    rd(2'd2, 32'h1);        // e8 sees capture after e7
    rd(2'd0, 32'h1);

    // DUT B: falling-edge mode, INIT=F
    pio_b = 4'hB;
    idle(5);
    rd(2'd0, 32'hF, 1'b1);  // e6
    rd(2'd0, 32'hB, 1'b1);  // e7
    rd(2'd2, 32'h4, 1'b1);  // e8
    check("irq_b_masked", {31'b0, irq_b}, 32'h0);
    pio_b = 4'hF;           // rising edge ignored in falling mode
    idle(10);
    rd(2'd2, 32'h4, 1'b1);
    rd(2'd0, 32'hF, 1'b1);

    idle(3);
    check("queue_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debounced_edge_pio.md
DEBOUNCED_EDGE_PIO -- requirements
Module: debounced_edge_pio

Interface
REQ-001 Parameter: WIDTH, default 4, number of input channels (1..32).
REQ-002 Parameter: DEBOUNCE_CYCLES, default 50000, stable-cycle count before a channel change is accepted (>=2).
REQ-003 Parameter: EDGE_MODE, default 0, capture qualifier: 0 rising, 1 falling, 2 any edge.
REQ-004 Parameter: INIT, default 0, WIDTH-bit reset value of debounced state (all-ones for active-low pushbuttons).
REQ-005 clk_clk  in  1  sole clock; all state on its rising edge.
REQ-006 reset_reset  in  1  synchronous, active-high reset.
REQ-007 pio_in  in  WIDTH  raw asynchronous inputs (switches/pushbuttons).
REQ-008 address  in  2  Avalon-MM word address.
REQ-009 read  in  1  read strobe.
REQ-010 write  in  1  write strobe.
REQ-011 writedata  in  32  write data.
REQ-012 readdata  out  32  read data, registered.
REQ-013 irq  out  1  level interrupt.

Function
REQ-014 Each channel SHALL pass through a 2-flop synchroniser (sync) before any other logic.
REQ-015 Each channel SHALL own a counter of width clog2(DEBOUNCE_CYCLES): cleared when sync == stable; incremented when sync != stable.
REQ-016 When sync != stable and counter == DEBOUNCE_CYCLES-1, stable SHALL take sync and counter SHALL clear on that edge.
REQ-017 Total latency: a pio_in change held steady SHALL appear in stable exactly DEBOUNCE_CYCLES+2 clock edges after first sampled.
REQ-018 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL NOT change stable; its counter SHALL restart from 0 on return.
REQ-019 stable_d SHALL register stable each cycle; a qualifying edge (per EDGE_MODE) of stable vs stable_d SHALL set edge_capture[i] on the next edge.
REQ-020 Register map (read): 0 = stable; 1 = irq_mask; 2 = edge_capture; 3 = sync (raw synchronised); bits above WIDTH read 0.
REQ-021 Register map (write): 1 = irq_mask <= writedata[WIDTH-1:0]; 2 = edge_capture cleared where writedata bit is 1 (W1C); writes to 0 and 3 ignored.
REQ-022 readdata SHALL be valid the cycle after read asserts (read latency 1); readdata holds its last value when read is low.
REQ-023 Simultaneous set and W1C on the same edge_capture bit: set SHALL win.
REQ-024 Simultaneous read and write to same address: readdata SHALL return pre-write value.
REQ-025 irq SHALL equal |(edge_capture & irq_mask), combinational from registers only, no extra latency.
REQ-026 Masking does not gate capture: edge_capture SHALL record edges regardless of irq_mask.
REQ-027 Counters SHALL never wrap; saturation is impossible by REQ-016.

Reset
REQ-028 During reset_reset: sync and stable and stable_d <= INIT, counters <= 0, irq_mask <= 0, edge_capture <= 0, readdata <= 0, irq = 0.
REQ-029 Reset asserted mid-debounce SHALL abandon the pending change; no edge SHALL be captured on reset release when pio_in equals INIT.
REQ-030 If pio_in differs from INIT at release, normal debounce SHALL apply and an edge SHALL be captured after DEBOUNCE_CYCLES+3 edges.

Verification (WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=0, INIT=0)
REQ-031 pio_in 0->4'b0001 held -> stable reads 1 after 6 edges, edge_capture[0]=1 after 7, irq=0 (mask 0).
REQ-032 Write mask=1 at addr 1, then REQ-031 stimulus -> irq rises with edge_capture[0]; write 1 to addr 2 -> irq falls next cycle.
REQ-033 pio_in[1] pulses high 3 cycles, repeated 5 times -> stable[1] stays 0, edge_capture stays 0.
REQ-034 W1C to bit 0 on same edge a new rising edge on bit 0 is captured -> edge_capture[0] remains 1.
REQ-035 EDGE_MODE=1, INIT=4'hF, pio_in=F, drop bit 2 -> stable=4'hB, edge_capture=4'h4; raising bit 2 back captures nothing new.
REQ-036 Reset asserted 2 cycles into a debounce, pio_in=0 at release -> stable=0, edge_capture=0, irq=0 throughout.
